// File: rtl/ace_ccu_snoop_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// ace_ccu_snoop_scheduler_pkg
// Shared constants and helpers for the CCU snoop scheduler and its tag table.
//   STATS_W   : width of the conflict statistics counter.
//   rr_wrap() : wraps a candidate requester index back into [0, n).
// ---------------------------------------------------------------------------
package ace_ccu_snoop_scheduler_pkg;

    localparam int unsigned STATS_W = 16;

    // Candidate indices never exceed 2*n-2, so a single subtract is enough
    // to bring them back into range; this works for any n, not just powers of two.
    function automatic int unsigned rr_wrap(input int unsigned i, input int unsigned n);
        return (i >= n) ? (i - n) : i;
    endfunction

endpackage

// File: rtl/ace_ccu_sched_table.sv
// ---------------------------------------------------------------------------
// ace_ccu_sched_table
// Tag table for outstanding snoops. Each entry holds {valid, line index}.
//   clk, rst       : clock, asynchronous active-high reset (clears valid bits)
//   req_addr       : per-requester line index to test for conflicts
//   match          : per-requester hit against any valid entry (current state)
//   free_avail     : at least one entry is invalid
//   alloc_tag      : lowest-index invalid entry
//   alloc/alloc_addr : write {valid=1, alloc_addr} into alloc_tag at the edge
//   free/free_tag  : clear entry free_tag at the edge (no-op if already invalid)
//   occupancy      : registered count of valid entries
// ---------------------------------------------------------------------------
module ace_ccu_sched_table
    import ace_ccu_snoop_scheduler_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned CmAddrWidth    = 8,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned TagWidth       = $clog2(MaxOutstanding)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NumReq-1:0][CmAddrWidth-1:0]    req_addr,
    output logic [NumReq-1:0]                     match,
    output logic                                  free_avail,
    output logic [TagWidth-1:0]                   alloc_tag,
    input  logic                                  alloc,
    input  logic [CmAddrWidth-1:0]                alloc_addr,
    input  logic                                  free,
    input  logic [TagWidth-1:0]                   free_tag,
    output logic [TagWidth:0]                     occupancy
);

    logic [MaxOutstanding-1:0] valid_reg;
    logic [CmAddrWidth-1:0]    addr_reg [MaxOutstanding];
    logic [TagWidth:0]         occupancy_reg;
    logic [TagWidth:0]         occupancy_next;
    logic                      free_hit;

    // Conflict match against the table as it stands this cycle; an entry
    // being freed this cycle still blocks until the edge clears it.
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_match
        logic hit;
        always_comb begin
            hit = 1'b0;
            for (int e = 0; e < int'(MaxOutstanding); e++) begin
                if (valid_reg[e] && (addr_reg[e] == req_addr[gi])) begin
                    hit = 1'b1;
                end
            end
        end
        assign match[gi] = hit;
    end

    // Lowest free entry: scan high to low so the last write wins.
    always_comb begin
        free_avail = 1'b0;
        alloc_tag  = '0;
        for (int e = int'(MaxOutstanding) - 1; e >= 0; e--) begin
            if (!valid_reg[e]) begin
                free_avail = 1'b1;
                alloc_tag  = TagWidth'(e);
            end
        end
    end

    // The allocated entry is invalid and a free only counts on a valid entry,
    // so both updates can never target the same entry in one cycle.
    assign free_hit = free && valid_reg[free_tag];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
        end else begin
            if (alloc) begin
                valid_reg[alloc_tag] <= 1'b1;
            end
            if (free_hit) begin
                valid_reg[free_tag] <= 1'b0;
            end
        end
    end

    // Address storage needs no reset: it is only observed through valid bits.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_reg[alloc_tag] <= alloc_addr;
        end
    end

    always_comb begin
        occupancy_next = occupancy_reg;
        if (alloc) begin
            occupancy_next = occupancy_next + (TagWidth+1)'(1);
        end
        if (free_hit) begin
            occupancy_next = occupancy_next - (TagWidth+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= occupancy_next;
        end
    end

    assign occupancy = occupancy_reg;

endmodule

// File: rtl/ace_ccu_snoop_scheduler.sv
// ---------------------------------------------------------------------------
// ace_ccu_snoop_scheduler
// Round-robin arbiter that issues snoop requests to the snoop interconnect,
// never allowing two in-flight snoops to the same cache line.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   req_valid_i/req_addr_i  : per-requester request and line index
//   req_ready_o             : one-hot acceptance pulse (combinational)
//   grant_valid_o/grant_ready_i, grant_idx_o/addr_o/tag_o : registered grant
//   done_valid_i/done_tag_i : retirement of an outstanding snoop
//   busy_o, occupancy_o     : table status (registered)
//   conflict_cnt_o          : cycles with an address-blocked request
// Optional feature: define ACE_CCU_SNOOP_SCHED_STATS_EN to build the
// saturating conflict counter; otherwise conflict_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module ace_ccu_snoop_scheduler
    import ace_ccu_snoop_scheduler_pkg::*;
#(
    parameter int unsigned NumReq         = 4,
    parameter int unsigned CmAddrWidth    = 8,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned TagWidth       = $clog2(MaxOutstanding),
    parameter int unsigned IdxWidth       = $clog2(NumReq)
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NumReq-1:0]                     req_valid_i,
    input  logic [NumReq-1:0][CmAddrWidth-1:0]    req_addr_i,
    output logic [NumReq-1:0]                     req_ready_o,
    output logic                                  grant_valid_o,
    input  logic                                  grant_ready_i,
    output logic [IdxWidth-1:0]                   grant_idx_o,
    output logic [CmAddrWidth-1:0]                grant_addr_o,
    output logic [TagWidth-1:0]                   grant_tag_o,
    input  logic                                  done_valid_i,
    input  logic [TagWidth-1:0]                   done_tag_i,
    output logic                                  busy_o,
    output logic [TagWidth:0]                     occupancy_o,
    output logic [STATS_W-1:0]                    conflict_cnt_o
);

    logic [NumReq-1:0]      match;
    logic [NumReq-1:0]      eligible;
    logic                   free_avail;
    logic [TagWidth-1:0]    alloc_tag;
    logic                   found;
    logic [IdxWidth-1:0]    winner;
    logic                   load;
    logic [IdxWidth-1:0]    rr_reg;

    logic                   grant_valid_reg;
    logic [IdxWidth-1:0]    grant_idx_reg;
    logic [CmAddrWidth-1:0] grant_addr_reg;
    logic [TagWidth-1:0]    grant_tag_reg;

    ace_ccu_sched_table #(
        .NumReq         (NumReq),
        .CmAddrWidth    (CmAddrWidth),
        .MaxOutstanding (MaxOutstanding),
        .TagWidth       (TagWidth)
    ) u_table (
        .clk        (clk_i),
        .rst        (rst_i),
        .req_addr   (req_addr_i),
        .match      (match),
        .free_avail (free_avail),
        .alloc_tag  (alloc_tag),
        .alloc      (load),
        .alloc_addr (req_addr_i[winner]),
        .free       (done_valid_i),
        .free_tag   (done_tag_i),
        .occupancy  (occupancy_o)
    );

    assign eligible = req_valid_i & ~match;

    // Rotate-and-find-first: walk requesters starting at the RR pointer and
    // take the first eligible one.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            int unsigned cand;
            cand = rr_wrap(int'(rr_reg) + k, NumReq);
            if (!found && eligible[cand]) begin
                found  = 1'b1;
                winner = IdxWidth'(cand);
            end
        end
    end

    // A full table blocks loading even if a done arrives this cycle, because
    // free_avail reflects the table before the edge.
    assign load = found && free_avail && (!grant_valid_reg || grant_ready_i);

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
        assign req_ready_o[gi] = load && (winner == IdxWidth'(gi));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_reg <= '0;
        end else if (load) begin
            rr_reg <= (winner == IdxWidth'(NumReq - 1)) ? '0 : winner + IdxWidth'(1);
        end
    end

    // Grant holds every field until accepted; a new load may replace it in
    // the same cycle it is accepted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            grant_valid_reg <= 1'b0;
            grant_idx_reg   <= '0;
            grant_addr_reg  <= '0;
            grant_tag_reg   <= '0;
        end else if (load) begin
            grant_valid_reg <= 1'b1;
            grant_idx_reg   <= winner;
            grant_addr_reg  <= req_addr_i[winner];
            grant_tag_reg   <= alloc_tag;
        end else if (grant_ready_i) begin
            grant_valid_reg <= 1'b0;
        end
    end

    assign grant_valid_o = grant_valid_reg;
    assign grant_idx_o   = grant_idx_reg;
    assign grant_addr_o  = grant_addr_reg;
    assign grant_tag_o   = grant_tag_reg;
    assign busy_o        = (occupancy_o != '0);

`ifdef ACE_CCU_SNOOP_SCHED_STATS_EN
    logic [STATS_W-1:0] conflict_reg;
    logic               blocked;

    assign blocked = |(req_valid_i & match);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            conflict_reg <= '0;
        end else if (blocked && !(&conflict_reg)) begin
            conflict_reg <= conflict_reg + STATS_W'(1);
        end
    end

    assign conflict_cnt_o = conflict_reg;
`else
    assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ace_ccu_snoop_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ace_ccu_snoop_scheduler
// Directed stimulus with a behavioural reference model of the scheduler:
// the table is a plain array of {valid, addr}, arbitration is a search from
// the round-robin pointer. The model is compared against the DUT on every
// falling edge, and directed sections add literal expectations.
// ---------------------------------------------------------------------------
module tb_ace_ccu_snoop_scheduler;

    localparam int NR = 4;
    localparam int AW = 8;
    localparam int MO = 8;
    localparam int TW = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0][AW-1:0] req_addr;
    logic [NR-1:0]     req_ready;
    logic              grant_valid;
    logic              grant_ready;
    logic [IW-1:0]     grant_idx;
    logic [AW-1:0]     grant_addr;
    logic [TW-1:0]     grant_tag;
    logic              done_valid;
    logic [TW-1:0]     done_tag;
    logic              busy;
    logic [TW:0]       occupancy;
    logic [15:0]       conflict_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ace_ccu_snoop_scheduler dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_addr_i     (req_addr),
        .req_ready_o    (req_ready),
        .grant_valid_o  (grant_valid),
        .grant_ready_i  (grant_ready),
        .grant_idx_o    (grant_idx),
        .grant_addr_o   (grant_addr),
        .grant_tag_o    (grant_tag),
        .done_valid_i   (done_valid),
        .done_tag_i     (done_tag),
        .busy_o         (busy),
        .occupancy_o    (occupancy),
        .conflict_cnt_o (conflict_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_valid [MO];
    logic [7:0]  m_addr  [MO];
    bit          m_gv;
    int          m_gidx;
    logic [7:0]  m_gaddr;
    int          m_gtag;
    int          m_rr;
    int          m_cnt;

    function automatic bit m_hit(input logic [7:0] a);
        for (int e = 0; e < MO; e++) begin
            if (m_valid[e] && m_addr[e] == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin : model
        int      win;
        int      tag;
        int      occ;
        int      j;
        bit      blocked;
        bit      ld;
        bit      done_hit;
        logic [3:0] exp_ready;

        if (rst) begin
            for (int e = 0; e < MO; e++) m_valid[e] = 1'b0;
            m_gv = 1'b0; m_gidx = 0; m_gaddr = 8'h00; m_gtag = 0;
            m_rr = 0; m_cnt = 0;
        end

        occ = 0;
        for (int e = 0; e < MO; e++) occ += int'(m_valid[e]);

        check("m_grant_valid", grant_valid, m_gv);
        check("m_grant_idx", grant_idx, m_gidx);
        check("m_grant_addr", grant_addr, m_gaddr);
        check("m_grant_tag", grant_tag, m_gtag);
        check("m_occupancy", occupancy, occ);
        check("m_busy", busy, occ != 0);
`ifdef ACE_CCU_SNOOP_SCHED_STATS_EN
        check("m_conflict_cnt", conflict_cnt, m_cnt);
`else
        check("m_conflict_cnt", conflict_cnt, 0);
`endif

        if (!rst && grant_valid && grant_ready)
            $display("grant idx=%0d addr=0x%02h tag=%0d t=%0t", grant_idx, grant_addr, grant_tag, $time);

        blocked = 1'b0;
        win = -1;
        for (int k = 0; k < NR; k++) begin
            j = (m_rr + k) % NR;
            if (req_valid[j] && m_hit(req_addr[j])) blocked = 1'b1;
            if (win < 0 && req_valid[j] && !m_hit(req_addr[j])) win = j;
        end
        tag = -1;
        for (int e = 0; e < MO; e++) if (tag < 0 && !m_valid[e]) tag = e;
        ld = (win >= 0) && (tag >= 0) && (!m_gv || grant_ready);
        exp_ready = ld ? (4'b0001 << win) : 4'b0000;
        check("m_req_ready", req_ready, exp_ready);

        if (!rst) begin
            done_hit = done_valid && m_valid[done_tag];
            if (ld) begin
                m_valid[tag] = 1'b1;
                m_addr[tag]  = req_addr[win];
                m_gv = 1'b1; m_gidx = win; m_gaddr = req_addr[win]; m_gtag = tag;
                m_rr = (win + 1) % NR;
            end else if (grant_ready) begin
                m_gv = 1'b0;
            end
            if (done_hit) m_valid[done_tag] = 1'b0;
            if (blocked && m_cnt < 65535) m_cnt++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        rst = 1'b1; req_valid = '0; req_addr = '0;
        grant_ready = 1'b1; done_valid = 1'b0; done_tag = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_busy", busy, 0);
        check("rst_conflict", conflict_cnt, 0);
        step();
        rst = 1'b0;

        // Round robin: all four valid, distinct lines.
        for (int k = 0; k < NR; k++) req_addr[k] = 8'h20 + 8'(k);
        req_valid = 4'hF;
        @(negedge clk);
        for (int k = 0; k < NR; k++) begin
            check("rr_ready", req_ready, 4'b0001 << k);
            if (k > 0) begin
                check("rr_idx", grant_idx, k - 1);
                check("rr_tag", grant_tag, k - 1);
            end
            step();
            req_valid[k] = 1'b0;
            @(negedge clk);
        end
        check("rr_idx_last", grant_idx, 3);
        check("rr_tag_last", grant_tag, 3);
        check("rr_occupancy", occupancy, 4);
        for (int t = 0; t < 4; t++) begin
            step(); done_valid = 1'b1; done_tag = 3'(t);
        end
        step(); done_valid = 1'b0;
        @(negedge clk);
        check("rr_drained", occupancy, 0);

        // Single request.
        step(); req_valid = 4'b0001; req_addr[0] = 8'h12;
        @(negedge clk);
        check("single_ready", req_ready, 4'b0001);
        step(); req_valid = 4'b0000;
        @(negedge clk);
        check("single_gv", grant_valid, 1);
        check("single_idx", grant_idx, 0);
        check("single_addr", grant_addr, 8'h12);
        check("single_tag", grant_tag, 0);
        check("single_occ", occupancy, 1);

        // Conflict hold on line 0x12.
        step(); req_valid = 4'b0100; req_addr[2] = 8'h12;
        @(negedge clk); check("conflict_ready_a", req_ready, 0);
        step();
        @(negedge clk); check("conflict_ready_b", req_ready, 0);
        step(); done_valid = 1'b1; done_tag = 3'd0;
        @(negedge clk); check("conflict_done_same_cycle", req_ready, 0);
        step(); done_valid = 1'b0;
        @(negedge clk); check("conflict_release", req_ready, 4'b0100);
        step(); req_valid = 4'b0000;
        @(negedge clk);
        check("conflict_idx", grant_idx, 2);
        check("conflict_tag_reuse", grant_tag, 0);
        step(); done_valid = 1'b1; done_tag = 3'd0;
        step(); done_valid = 1'b0;

        // Fill the table.
        for (int k = 0; k < MO; k++) begin
            step();
            req_valid = 4'b0000;
            req_valid[k % NR] = 1'b1;
            req_addr[k % NR] = 8'h40 + 8'(k);
            @(negedge clk);
            check("fill_ready", req_ready, 4'b0001 << (k % NR));
        end
        step(); req_valid = 4'b0010; req_addr[1] = 8'h50;
        @(negedge clk);
        check("full_ready", req_ready, 0);
        check("full_occ", occupancy, 8);
        step(); done_valid = 1'b1; done_tag = 3'd5;
        @(negedge clk); check("full_done_same_cycle", req_ready, 0);
        step(); done_valid = 1'b0;
        @(negedge clk); check("full_after_done", req_ready, 4'b0010);
        step(); req_valid = 4'b0000;
        @(negedge clk);
        check("full_tag5", grant_tag, 5);
        check("full_addr", grant_addr, 8'h50);
        check("full_occ_again", occupancy, 8);
        for (int t = 0; t < MO; t++) begin
            step(); done_valid = 1'b1; done_tag = 3'(t);
        end
        step(); done_valid = 1'b0;
        @(negedge clk); check("full_drained", occupancy, 0);

        // Backpressure.
        step(); grant_ready = 1'b0; req_valid = 4'b0001; req_addr[0] = 8'h60;
        @(negedge clk); check("bp_first_ready", req_ready, 4'b0001);
        step(); req_valid = 4'b0010; req_addr[1] = 8'h61;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_hold_ready", req_ready, 0);
            check("bp_hold_gv", grant_valid, 1);
            check("bp_hold_idx", grant_idx, 0);
            check("bp_hold_addr", grant_addr, 8'h60);
            step();
        end
        grant_ready = 1'b1;
        @(negedge clk); check("bp_release_ready", req_ready, 4'b0010);
        step(); req_valid = 4'b0000;
        @(negedge clk);
        check("bp_next_idx", grant_idx, 1);
        check("bp_next_addr", grant_addr, 8'h61);

        // Reset mid-flight with three outstanding.
        step(); req_valid = 4'b0100; req_addr[2] = 8'h70;
        step(); req_valid = 4'b0000;
        @(negedge clk); check("mid_occ3", occupancy, 3);
        step(); rst = 1'b1;
        @(negedge clk);
        check("mid_rst_occ", occupancy, 0);
        check("mid_rst_gv", grant_valid, 0);
        check("mid_rst_conflict", conflict_cnt, 0);
        step(); rst = 1'b0;
        done_valid = 1'b1; done_tag = 3'd0;
        req_valid = 4'b0011; req_addr[0] = 8'h80; req_addr[1] = 8'h81;
        @(negedge clk); check("post_rst_rr0", req_ready, 4'b0001);
        step(); done_valid = 1'b0; req_valid = 4'b0010;
        @(negedge clk);
        check("post_rst_ready1", req_ready, 4'b0010);
        check("post_rst_done_ignored", occupancy, 1);
        check("post_rst_tag", grant_tag, 0);
        step(); req_valid = 4'b0000;
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ace_ccu_snoop_scheduler.md
Name: ace_ccu_snoop_scheduler

Overview:
- Arbitrates snoop-transaction requests from the CCU groups onto the single snoop interconnect input.
- Tracks every outstanding snoop by its cache-line index (CmAddrWidth bits) in a small tag table.
- Never issues two in-flight snoops to the same line; a conflicting requester is held until the owning snoop retires.
- Sits between the per-group master paths and ace_ccu_snoop_interconnect; replaces the free-running conflict-stall handshake.

Parameters:
- NumReq, 4, number of requesters (2 per group); must be >= 2.
- CmAddrWidth, 8, width of the cache-line index compared for conflicts.
- MaxOutstanding, 8, tag table depth; power of two, >= 2.
- TagWidth, $clog2(MaxOutstanding), derived; not to be overridden.
- IdxWidth, $clog2(NumReq), derived; not to be overridden.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  NumReq  request valid per requester.
- req_addr_i  in  NumReq x CmAddrWidth  line index per requester.
- req_ready_o  out  NumReq  one-hot acceptance pulse.
- grant_valid_o  out  1  registered grant valid.
- grant_ready_i  in  1  interconnect accepts grant.
- grant_idx_o  out  IdxWidth  index of granted requester.
- grant_addr_o  out  CmAddrWidth  granted line index.
- grant_tag_o  out  TagWidth  table tag allocated to grant.
- done_valid_i  in  1  snoop retired.
- done_tag_i  in  TagWidth  tag of retired snoop.
- busy_o  out  1  any table entry valid.
- occupancy_o  out  TagWidth+1  count of valid entries.
- conflict_cnt_o  out  16  conflict statistics (see Optional Feature).

Behaviour:
- Reset values (async on rst_i high):
  - all table entries invalid;
  - RR pointer = 0;
  - grant_valid_o = 0; grant_idx_o, grant_addr_o, grant_tag_o = 0;
  - busy_o = 0; occupancy_o = 0; conflict_cnt_o = 0.
- Reset mid-operation discards all outstanding tags; done_valid_i referring to pre-reset tags is ignored after reset.
- Eligibility: requester i is eligible iff req_valid_i[i] and req_addr_i[i] matches no valid table entry. Comparison uses the current-cycle table state.
- Accept condition (load): at least one eligible requester, a free table entry exists, and (!grant_valid_o || grant_ready_i).
- On load:
  - winner = first eligible requester at or after the RR pointer, wrapping modulo NumReq;
  - req_ready_o[winner] = 1 combinationally, all other bits 0;
  - tag = lowest-index free entry; entry written {valid=1, addr};
  - grant_* registered next cycle;
  - RR pointer = (winner+1) mod NumReq.
- Latency: req_valid_i at cycle N (eligible, slot free, output empty) -> grant_valid_o at N+1. Back-to-back grants are possible every cycle.
- Grant output holds grant_valid_o and all grant_* fields stable until grant_ready_i is high. The table entry is already allocated while the grant waits.
- Requesters must hold req_valid_i and req_addr_i stable until their req_ready_o bit is high. req_ready_o never asserts without valid.
- Done: done_valid_i clears entry done_tag_i at the clock edge.
  - Done on an already-invalid entry is ignored.
  - A freed entry is not reusable in the same cycle.
  - The freed address still blocks in that cycle; it becomes eligible the next cycle.
- Full (occupancy == MaxOutstanding): no load, all req_ready_o = 0. A simultaneous done does not allow a same-cycle load.
- Same-cycle requesters with identical addresses: only one is granted; the other conflicts from the next cycle until done.
- occupancy_o = popcount(valid), registered. busy_o = occupancy_o != 0.

Optional Feature:
- Macro: ACE_CCU_SNOOP_SCHED_STATS_EN.
- Defined: conflict_cnt_o increments by 1 in every cycle where at least one req_valid_i is blocked solely by an address match. The counter saturates at 16'hFFFF and clears on reset.
- Undefined: conflict_cnt_o is tied to 0 and no counter logic is generated.

Decomposition:
- ace_pkg gains sched_entry_t {logic valid; logic [CmAddrWidth-1:0] addr} via a typedef macro in ace/typedef.svh.
- One sub-module: ace_ccu_sched_table. It holds the entry array, per-requester match vector, lowest-free-tag encoder, allocate/free ports and occupancy.
- Round-robin selection stays in the top (lzc-based rotate).

Test Plan:
- Single request: req 0 with addr 0x12 -> req_ready_o=4'b0001 in the same cycle; grant_valid_o=1, idx=0, addr=0x12, tag=0 next cycle; occupancy_o=1.
- Conflict hold: tag 0 holds 0x12; req 2 with addr 0x12 -> stalled. done_tag_i=0 at cycle T -> req 2 accepted at T+1, tag 0 reused.
- Round-robin fairness: all 4 requesters valid with distinct addresses, grant_ready_i=1 -> grant_idx_o sequence 0,1,2,3 with tags 0..3.
- Full table: 8 grants outstanding -> req_ready_o=0. Done on tag 5 with a new request in the same cycle -> no accept; accepted next cycle with tag 5.
- Backpressure: grant_ready_i=0 for 3 cycles -> grant fields stable, no new req_ready_o. Release -> next grant the following cycle.
- Reset mid-flight: 3 outstanding, rst_i pulse -> occupancy_o=0, grant_valid_o=0. Stats build: conflict_cnt_o=0, and 5 blocked cycles -> 5.
